// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa product,
// then normalise, round (RNe/RNa/RZ/RU/RD), and pack with IEEE flags.
module fp_mul_seq #(
    parameter int unsigned W = 32,
    parameter int unsigned M = 22,
    parameter int unsigned E = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         act,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [2:0]   round_m,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out,
    output logic         ov,
    output logic         un,
    output logic         inv,
    output logic         inexact
);

    localparam int unsigned MW   = M + 1;
    localparam int unsigned EW   = E - M;
    localparam int unsigned SW   = MW + 1;
    localparam int unsigned PW   = 2 * SW;
    localparam int unsigned XW   = EW + 2;
    localparam int unsigned CW   = $clog2(SW);
    localparam int unsigned BIAS = (1 << (EW - 1)) - 1;

    localparam logic [EW-1:0] EXP_ONES = {EW{1'b1}};
    localparam logic [W-1:0]  INF      = {1'b0, {EW{1'b1}}, {MW{1'b0}}};
    localparam logic [W-1:0]  MAXF     = {1'b0, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
    localparam logic [W-1:0]  NANQ     = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RNA = 3'd1;
    localparam logic [2:0] RM_RZ  = 3'd2;
    localparam logic [2:0] RM_RU  = 3'd3;
    localparam logic [2:0] RM_RD  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]    rm_q, rm_d;
    logic          spec_q, spec_d, spec_inv_q, spec_inv_d;
    logic [W-1:0]  spec_res_q, spec_res_d;
    logic [XW-1:0] esum_q, esum_d;
    logic [PW-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [SW-1:0] mult_q, mult_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] rnd_exp_q, rnd_exp_d;
    logic [MW-1:0] rnd_man_q, rnd_man_d;
    logic          rnd_inx_q, rnd_inx_d;
    logic [W-1:0]  out_q, out_d;
    logic          ov_q, ov_d, un_q, un_d, inv_q, inv_d, inexact_q, inexact_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic [EW-1:0] ea, eb;
    logic [MW-1:0] fa, fb;
    logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, sign;

    assign ea     = a_q[E:M+1];
    assign eb     = b_q[E:M+1];
    assign fa     = a_q[M:0];
    assign fb     = b_q[M:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_snan = a_nan && !fa[MW-1];
    assign b_snan = b_nan && !fb[MW-1];
    assign sign   = a_q[W-1] ^ b_q[W-1];

    // Normalise the accumulated product and decide the rounding increment.
    logic [MW-1:0] man;
    logic [MW:0]   man_inc;
    logic [XW-1:0] exp_n;
    logic          guard, sticky, inc;

    always_comb begin
        if (acc_q[PW-1]) begin
            man    = acc_q[PW-2 -: MW];
            guard  = acc_q[PW-2-MW];
            sticky = |acc_q[PW-3-MW:0];
            exp_n  = esum_q + XW'(1);
        end else begin
            man    = acc_q[PW-3 -: MW];
            guard  = acc_q[PW-3-MW];
            sticky = |acc_q[PW-4-MW:0];
            exp_n  = esum_q;
        end
        inc = 1'b0;
        case (rm_q)
            RM_RNA:  inc = guard;
            RM_RZ:   inc = 1'b0;
            RM_RU:   inc = !sign && (guard || sticky);
            RM_RD:   inc = sign && (guard || sticky);
            default: inc = guard && (sticky || man[0]);
        endcase
        man_inc = {1'b0, man} + SW'(inc);
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rm_d       = rm_q;
        spec_d     = spec_q;
        spec_inv_d = spec_inv_q;
        spec_res_d = spec_res_q;
        esum_d     = esum_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mult_d     = mult_q;
        cnt_d      = cnt_q;
        rnd_exp_d  = rnd_exp_q;
        rnd_man_d  = rnd_man_q;
        rnd_inx_d  = rnd_inx_q;
        out_d      = out_q;
        ov_d       = ov_q;
        un_d       = un_q;
        inv_d      = inv_q;
        inexact_d  = inexact_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (act && !done_q) begin
                    state_d = S_LOAD;
                    a_d     = in1;
                    b_d     = in2;
                    rm_d    = round_m;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                mcand_d    = PW'({1'b1, fa});
                mult_d     = {1'b1, fb};
                acc_d      = '0;
                cnt_d      = '0;
                esum_d     = XW'(ea) + XW'(eb) - XW'(BIAS);
                spec_d     = 1'b1;
                spec_inv_d = 1'b0;
                spec_res_d = NANQ;
                if (a_nan || b_nan)
                    spec_inv_d = a_snan || b_snan;
                else if ((a_zero && b_inf) || (a_inf && b_zero))
                    spec_inv_d = 1'b1;
                else if (a_inf || b_inf)
                    spec_res_d = {sign, INF[W-2:0]};
                else if (a_zero || b_zero)
                    spec_res_d = {sign, {(W-1){1'b0}}};
                else
                    spec_d = 1'b0;
                state_d = S_MUL;
            end
            S_MUL: begin
                acc_d   = acc_q + (mult_q[0] ? mcand_q : '0);
                mcand_d = mcand_q << 1;
                mult_d  = mult_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(SW - 1))
                    state_d = S_ROUND;
            end
            S_ROUND: begin
                // A carry out of the mantissa leaves man_inc[MW-1:0] at zero, i.e. 1.0 x 2^(e+1).
                rnd_exp_d = exp_n + XW'(man_inc[MW]);
                rnd_man_d = man_inc[MW-1:0];
                rnd_inx_d = guard || sticky;
                state_d   = S_DONE;
            end
            S_DONE: begin
                ov_d      = 1'b0;
                un_d      = 1'b0;
                inv_d     = 1'b0;
                inexact_d = 1'b0;
                if (spec_q) begin
                    out_d = spec_res_q;
                    inv_d = spec_inv_q;
                end else if (!rnd_exp_q[XW-1] && (rnd_exp_q >= XW'(EXP_ONES))) begin
                    ov_d      = 1'b1;
                    inexact_d = 1'b1;
                    case (rm_q)
                        RM_RZ:   out_d = {sign, MAXF[W-2:0]};
                        RM_RU:   out_d = sign ? {1'b1, MAXF[W-2:0]} : INF;
                        RM_RD:   out_d = sign ? {1'b1, INF[W-2:0]} : MAXF;
                        default: out_d = {sign, INF[W-2:0]};
                    endcase
                end else if (rnd_exp_q[XW-1] || (rnd_exp_q == '0)) begin
                    un_d      = 1'b1;
                    inexact_d = 1'b1;
                    out_d     = {sign, {(W-1){1'b0}}};
                end else begin
                    out_d     = {sign, rnd_exp_q[EW-1:0], rnd_man_q};
                    inexact_d = rnd_inx_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            rm_q       <= '0;
            spec_q     <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_res_q <= '0;
            esum_q     <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mult_q     <= '0;
            cnt_q      <= '0;
            rnd_exp_q  <= '0;
            rnd_man_q  <= '0;
            rnd_inx_q  <= 1'b0;
            out_q      <= '0;
            ov_q       <= 1'b0;
            un_q       <= 1'b0;
            inv_q      <= 1'b0;
            inexact_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rm_q       <= rm_d;
            spec_q     <= spec_d;
            spec_inv_q <= spec_inv_d;
            spec_res_q <= spec_res_d;
            esum_q     <= esum_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mult_q     <= mult_d;
            cnt_q      <= cnt_d;
            rnd_exp_q  <= rnd_exp_d;
            rnd_man_q  <= rnd_man_d;
            rnd_inx_q  <= rnd_inx_d;
            out_q      <= out_d;
            ov_q       <= ov_d;
            un_q       <= un_d;
            inv_q      <= inv_d;
            inexact_q  <= inexact_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign out     = out_q;
    assign ov      = ov_q;
    assign un      = un_q;
    assign inv     = inv_q;
    assign inexact = inexact_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq: latency, rounding modes, overflow/underflow,
// special operands, ignored act pulses, back-to-back issue and mid-operation reset.
module tb_fp_mul_seq;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RNA = 3'd1;
    localparam logic [2:0] RZ  = 3'd2;
    localparam logic [2:0] RU  = 3'd3;
    localparam logic [2:0] RD  = 3'd4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [3:0]  fl;   // {ov, un, inv, inexact}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        act;
    logic [31:0] in1, in2;
    logic [2:0]  round_m;
    logic        busy, done, ov, un, inv, inexact;
    logic [31:0] out;

    int vectors    = 0;
    int miscompares = 0;

    fp_mul_seq dut (
        .clk     (clk),
        .rst     (rst),
        .act     (act),
        .in1     (in1),
        .in2     (in2),
        .round_m (round_m),
        .busy    (busy),
        .done    (done),
        .out     (out),
        .ov      (ov),
        .un      (un),
        .inv     (inv),
        .inexact (inexact)
    );

    always #5 clk = ~clk;

    // Issue one operation and wait (bounded) for done; cyc counts edges after the act edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                         output logic [31:0] r, output logic [3:0] f, output int cyc,
                         output logic bsy);
        @(negedge clk);
        in1 = a; in2 = b; round_m = rm; act = 1'b1;
        @(posedge clk); #1;
        act = 1'b0;
        cyc = 0;
        bsy = 1'b0;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) bsy = busy;
        end
        r = out;
        f = {ov, un, inv, inexact};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; act = 1'b0; in1 = '0; in2 = '0; round_m = RNE;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_out got=%h want=00000000", out);
        end
        vectors++;
        if ({busy, done, ov, un, inv, inexact} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_status got=%b want=000000", {busy, done, ov, un, inv, inexact});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] r; logic [3:0] f; int cyc; logic bsy;
        do_op(32'h3FC00000, 32'h40000000, RNE, r, f, cyc, bsy);
        vectors++;
        if (r !== 32'h40400000 || f !== 4'b0000) begin
            miscompares++;
            $display("FAIL basic_3p0 got=%h/%b want=40400000/0000", r, f);
        end
        vectors++;
        if (cyc !== 27) begin
            miscompares++;
            $display("FAIL basic_latency got=%0d want=27", cyc);
        end
        vectors++;
        if (bsy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy got=%b want=1", bsy);
        end
        do_op(32'hBFC00000, 32'h40000000, RZ, r, f, cyc, bsy);
        vectors++;
        if (r !== 32'hC0400000 || f !== 4'b0000) begin
            miscompares++;
            $display("FAIL basic_neg got=%h/%b want=C0400000/0000", r, f);
        end
    endtask

    task automatic test_rounding();
        vec_t tv [0:9];
        logic [31:0] r; logic [3:0] f; int cyc; logic bsy;
        tv = '{
            '{32'h3F800001, 32'h3F800001, RNE, 32'h3F800002, 4'b0001},
            '{32'h3F800001, 32'h3F800001, RU,  32'h3F800003, 4'b0001},
            '{32'h3F800001, 32'h3F800001, RD,  32'h3F800002, 4'b0001},
            '{32'hBF800001, 32'h3F800001, RD,  32'hBF800003, 4'b0001},
            '{32'hBF800001, 32'h3F800001, RU,  32'hBF800002, 4'b0001},
            '{32'h3FC00000, 32'h3F800003, RNE, 32'h3FC00004, 4'b0001},
            '{32'h3FC00000, 32'h3F800003, RNA, 32'h3FC00005, 4'b0001},
            '{32'h3FC00000, 32'h3F800003, RZ,  32'h3FC00004, 4'b0001},
            '{32'h3F800001, 32'h3FFFFFFE, RNE, 32'h40000000, 4'b0001},
            '{32'h3F800001, 32'h3FFFFFFE, RZ,  32'h3FFFFFFF, 4'b0001}
        };
        for (int i = 0; i < 10; i++) begin
            do_op(tv[i].a, tv[i].b, tv[i].rm, r, f, cyc, bsy);
            vectors++;
            if (r !== tv[i].res || f !== tv[i].fl) begin
                miscompares++;
                $display("FAIL round[%0d] got=%h/%b want=%h/%b", i, r, f, tv[i].res, tv[i].fl);
            end
        end
    endtask

    task automatic test_ov_un();
        vec_t tv [0:7];
        logic [31:0] r; logic [3:0] f; int cyc; logic bsy;
        tv = '{
            '{32'h7F000000, 32'h7F000000, RNE, 32'h7F800000, 4'b1001},
            '{32'h7F000000, 32'h7F000000, RZ,  32'h7F7FFFFF, 4'b1001},
            '{32'h7F000000, 32'h7F000000, RU,  32'h7F800000, 4'b1001},
            '{32'h7F000000, 32'h7F000000, RD,  32'h7F7FFFFF, 4'b1001},
            '{32'hFF000000, 32'h7F000000, RU,  32'hFF7FFFFF, 4'b1001},
            '{32'hFF000000, 32'h7F000000, RD,  32'hFF800000, 4'b1001},
            '{32'h00800000, 32'h3F000000, RNE, 32'h00000000, 4'b0101},
            '{32'h80800000, 32'h3F000000, RNE, 32'h80000000, 4'b0101}
        };
        for (int i = 0; i < 8; i++) begin
            do_op(tv[i].a, tv[i].b, tv[i].rm, r, f, cyc, bsy);
            vectors++;
            if (r !== tv[i].res || f !== tv[i].fl) begin
                miscompares++;
                $display("FAIL ovun[%0d] got=%h/%b want=%h/%b", i, r, f, tv[i].res, tv[i].fl);
            end
        end
    endtask

    task automatic test_specials();
        vec_t tv [0:6];
        logic [31:0] r; logic [3:0] f; int cyc; logic bsy;
        tv = '{
            '{32'h80000000, 32'h7F800000, RNE, 32'h7FC00000, 4'b0010},
            '{32'h7FC00001, 32'h3F800000, RNE, 32'h7FC00000, 4'b0000},
            '{32'h3F800000, 32'h7F800001, RNE, 32'h7FC00000, 4'b0010},
            '{32'hFF800000, 32'h40000000, RZ,  32'hFF800000, 4'b0000},
            '{32'h7F800000, 32'h7F800000, RNE, 32'h7F800000, 4'b0000},
            '{32'h80000000, 32'h40000000, RNE, 32'h80000000, 4'b0000},
            '{32'h00000001, 32'h3F800000, RNE, 32'h00000000, 4'b0000}
        };
        for (int i = 0; i < 7; i++) begin
            do_op(tv[i].a, tv[i].b, tv[i].rm, r, f, cyc, bsy);
            vectors++;
            if (r !== tv[i].res || f !== tv[i].fl || cyc !== 27) begin
                miscompares++;
                $display("FAIL special[%0d] got=%h/%b cyc=%0d want=%h/%b cyc=27",
                         i, r, f, cyc, tv[i].res, tv[i].fl);
            end
        end
    endtask

    task automatic test_ignore_act();
        int cyc; int ndone;
        @(negedge clk);
        in1 = 32'h3FC00000; in2 = 32'h40000000; round_m = RNE; act = 1'b1;
        @(posedge clk); #1;
        act = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 5) begin
                in1 = 32'h7F000000; in2 = 32'h7F000000; round_m = RZ; act = 1'b1;
            end else begin
                act = 1'b0;
            end
        end
        vectors++;
        if (out !== 32'h40400000 || {ov, un, inv, inexact} !== 4'b0000 || cyc !== 27) begin
            miscompares++;
            $display("FAIL ignore_act got=%h/%b cyc=%0d want=40400000/0000 cyc=27",
                     out, {ov, un, inv, inexact}, cyc);
        end
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL ignore_act_extra_done got=%0d want=0", ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic [3:0] f; int cyc; logic bsy;
        @(negedge clk);
        in1 = 32'h3F800001; in2 = 32'h3F800001; round_m = RU; act = 1'b1;
        @(posedge clk); #1;
        act = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (out !== 32'h3F800003 || cyc !== 27) begin
            miscompares++;
            $display("FAIL b2b_first got=%h cyc=%0d want=3F800003 cyc=27", out, cyc);
        end
        // act held across the done cycle: only the following edge may accept it
        in1 = 32'h3FC00000; in2 = 32'h3F800003; round_m = RNA; act = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        act = 1'b0;
        cyc = 2;
        while (done !== 1'b1 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
        end
        r = out;
        f = {ov, un, inv, inexact};
        vectors++;
        if (r !== 32'h3FC00005 || f !== 4'b0001 || cyc !== 29) begin
            miscompares++;
            $display("FAIL b2b_second got=%h/%b cyc=%0d want=3FC00005/0001 cyc=29", r, f, cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [3:0] f; int cyc; logic bsy; int ndone;
        @(negedge clk);
        in1 = 32'h7F000000; in2 = 32'h7F000000; round_m = RZ; act = 1'b1;
        @(posedge clk); #1;
        act = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0 || {ov, un, inv, inexact} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b done=%b out=%h flags=%b want 0/0/00000000/0000",
                     busy, done, out, {ov, un, inv, inexact});
        end
        ndone = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_stale_done got=%0d want=0", ndone);
        end
        do_op(32'h3F800001, 32'h3FFFFFFE, RNE, r, f, cyc, bsy);
        vectors++;
        if (r !== 32'h40000000 || f !== 4'b0001 || cyc !== 27) begin
            miscompares++;
            $display("FAIL reset_mid_after got=%h/%b cyc=%0d want=40000000/0001 cyc=27", r, f, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_ov_un();
        test_specials();
        test_ignore_act();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
